// File: rtl/secure_level_ctrl.sv
// Keyed, drain-acknowledged security-level controller for NUM_CH channels.
// Optional until-reset lock is built when SECURE_LEVEL_CTRL_LOCK_EN is defined.
module secure_level_ctrl #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned LVL_W      = 2,
  parameter int unsigned RST_LVL    = 0,
  parameter logic [31:0] KEY        = 32'h5EC0_0A5A,
  parameter int unsigned ARM_WINDOW = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic [NUM_CH*LVL_W-1:0]   sec_lvl_o,
  output logic [NUM_CH-1:0]         drain_req_o,
  input  logic [NUM_CH-1:0]         drain_ack_i,
  output logic                      change_o
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_MAX = (ARM_WINDOW > TIMEOUT) ? ARM_WINDOW : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned LV_W    = NUM_CH * LVL_W;
  localparam int unsigned E_NOKEY = 0;
  localparam int unsigned E_KEY   = 1;
  localparam int unsigned E_BUSY  = 2;
  localparam int unsigned E_ARG   = 3;
  localparam int unsigned E_TMO   = 4;
  localparam int unsigned E_LOCK  = 5;

  typedef enum logic [1:0] {IDLE, ARMED, DRAIN, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [LVL_W-1:0]  tgt_q, tgt_d;
  logic [5:0]        err_q, err_set, err_clr;
  logic [LV_W-1:0]   lvl_q;
  logic [NUM_CH-1:0] drain_d;
  logic [31:0]       status, rd_mux;
  logic              locked, lock_eff;
  logic              unused_addr;

  // Bus decode: only word index addr_i[4:2] matters
  logic [2:0] idx;
  logic       wr, key_wr, key_ok, ctrl_wr, stat_wr, ch_valid;
  assign idx      = addr_i[4:2];
  assign wr       = req_i && we_i;
  assign key_wr   = wr && (idx == 3'd2);
  assign key_ok   = key_wr && (be_i == 4'hF) && (wdata_i == KEY);
  assign ctrl_wr  = wr && (idx == 3'd1) && be_i[0];
  assign stat_wr  = wr && (idx == 3'd3) && be_i[0];
  assign ch_valid = wdata_i[15:8] < 8'(NUM_CH);
  assign err_clr  = stat_wr ? wdata_i[13:8] : 6'd0;
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

`ifdef SECURE_LEVEL_CTRL_LOCK_EN
  logic locked_q;
  logic lock_wr;
  assign lock_wr  = wr && (idx == 3'd4) && be_i[0] && wdata_i[0];
  assign locked   = locked_q;
  assign lock_eff = locked_q || lock_wr;

  // Lock is sticky until reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      locked_q <= 1'b0;
    else if (lock_wr) locked_q <= 1'b1;
  end
`else
  assign locked   = 1'b0;
  assign lock_eff = 1'b0;
`endif

  // Next-state logic and error detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    tgt_d   = tgt_q;
    err_set = '0;
    if (ctrl_wr && lock_eff) err_set[E_LOCK] = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (key_wr && !key_ok) begin
          err_set[E_KEY] = 1'b1;
        end else if (key_ok && !lock_eff) begin
          state_d = ARMED;
          cnt_d   = CNT_W'(ARM_WINDOW);
        end
        if (ctrl_wr && !lock_eff) err_set[E_NOKEY] = 1'b1;
      end
      ARMED: begin
        if (key_wr && !key_ok) begin
          err_set[E_KEY] = 1'b1;
          state_d        = IDLE;
        end else if (lock_eff) begin
          state_d = IDLE;
        end else if (key_ok) begin
          cnt_d = CNT_W'(ARM_WINDOW);
        end else if (ctrl_wr) begin
          if (ch_valid) begin
            ch_d    = CH_W'(wdata_i[15:8]);
            tgt_d   = wdata_i[LVL_W-1:0];
            cnt_d   = CNT_W'(TIMEOUT);
            state_d = DRAIN;
          end else begin
            err_set[E_ARG] = 1'b1;
            state_d        = IDLE;
          end
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DRAIN: begin
        if (key_wr || (ctrl_wr && !lock_eff)) err_set[E_BUSY] = 1'b1;
        if (drain_ack_i[ch_q]) begin
          state_d = COMMIT;
        end else if (cnt_q == '0) begin
          err_set[E_TMO] = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      COMMIT: begin
        if (key_wr || (ctrl_wr && !lock_eff)) err_set[E_BUSY] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Drain request targets only the latched channel while draining
  always_comb begin
    drain_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      drain_d[c] = (state_d == DRAIN) && (ch_d == CH_W'(c));
    end
  end

  assign status = {18'd0, err_q, 5'd0, locked, (state_q == ARMED),
                   (state_q == DRAIN) || (state_q == COMMIT)};

  always_comb begin
    rd_mux = '0;
    case (idx)
      3'd0:    rd_mux = 32'(lvl_q);
      3'd3:    rd_mux = status;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ch_q        <= '0;
      tgt_q       <= '0;
      err_q       <= '0;
      lvl_q       <= {NUM_CH{LVL_W'(RST_LVL)}};
      drain_req_o <= '0;
      change_o    <= 1'b0;
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      tgt_q       <= tgt_d;
      err_q       <= (err_q & ~err_clr) | err_set;
      drain_req_o <= drain_d;
      change_o    <= (state_d == COMMIT);
      rvalid_o    <= req_i;
      rdata_o     <= (req_i && !we_i) ? rd_mux : 32'd0;
      // Level is written on entry to COMMIT so it is visible with change_o
      if (state_d == COMMIT) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_d == CH_W'(c)) lvl_q[c*LVL_W +: LVL_W] <= tgt_d;
        end
      end
    end
  end

  assign sec_lvl_o = lvl_q;

endmodule

// File: tb/tb_secure_level_ctrl.sv
// Directed bench for secure_level_ctrl (default parameters); the lock section
// runs only when SECURE_LEVEL_CTRL_LOCK_EN is defined.
module tb_secure_level_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [3:0]  sec_lvl_o;
  logic [1:0]  drain_req_o;
  logic [1:0]  drain_ack_i = 2'b00;
  logic        change_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] A_LEVEL  = 32'h00;
  localparam logic [31:0] A_CTRL   = 32'h04;
  localparam logic [31:0] A_KEY    = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h0C;
  localparam logic [31:0] A_LOCK   = 32'h10;
  localparam logic [31:0] MAGIC    = 32'h5EC0_0A5A;

  secure_level_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .sec_lvl_o   (sec_lvl_o),
    .drain_req_o (drain_req_o),
    .drain_ack_i (drain_ack_i),
    .change_o    (change_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
    step();
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; be_i = 4'hF;
    step();
    req_i = 1'b0; be_i = 4'h0;
    chk({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
    chk(tag, rdata_o, exp);
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_drain", 32'(drain_req_o), 32'd0);
    chk("rst_change", 32'(change_o), 32'd0);
    chk("rst_lvl", 32'(sec_lvl_o), 32'd0);
    rst_ni = 1'b1;
    step();
    bus_read("level_rst", A_LEVEL, 32'd0);
    step();
    chk("rvalid_drop", 32'(rvalid_o), 32'd0);
    bus_read("status_rst", A_STATUS, 32'd0);

    // Key + CTRL ch1 lvl3, ack in the fifth drain cycle
    bus_write(A_KEY, MAGIC, 4'hF);
    chk("wr_rvalid", 32'(rvalid_o), 32'd1);
    chk("wr_rdata", rdata_o, 32'd0);
    bus_write(A_CTRL, 32'h0000_0103, 4'hF);
    for (int i = 0; i < 5; i++) begin
      chk("drain_hi", 32'(drain_req_o), 32'h2);
      chk("no_change", 32'(change_o), 32'd0);
      if (i < 4) step();
    end
    drain_ack_i = 2'b10;
    step();
    chk("commit_change", 32'(change_o), 32'd1);
    chk("commit_drain", 32'(drain_req_o), 32'd0);
    chk("commit_lvl", 32'(sec_lvl_o), 32'hC);
    drain_ack_i = 2'b00;
    step();
    chk("change_pulse", 32'(change_o), 32'd0);
    bus_read("level_c", A_LEVEL, 32'h0000_000C);

    // CTRL without key, then W1C
    bus_write(A_CTRL, 32'h0000_0001, 4'hF);
    bus_read("nokey", A_STATUS, 32'h100);
    bus_write(A_STATUS, 32'h100, 4'h1);
    bus_read("nokey_clr", A_STATUS, 32'd0);

    // Arm window expiry
    bus_write(A_KEY, MAGIC, 4'hF);
    bus_read("armed", A_STATUS, 32'h2);
    repeat (17) step();
    bus_read("window_gone", A_STATUS, 32'd0);
    bus_write(A_CTRL, 32'h0000_0101, 4'hF);
    chk("expired_drain", 32'(drain_req_o), 32'd0);
    bus_read("expired_err", A_STATUS, 32'h100);
    bus_read("expired_lvl", A_LEVEL, 32'h0000_000C);
    bus_write(A_STATUS, 32'h3F00, 4'hF);

    // Wrong key values and partial byte enables
    bus_write(A_KEY, 32'hDEAD_BEEF, 4'hF);
    bus_read("badkey", A_STATUS, 32'h200);
    bus_write(A_STATUS, 32'h200, 4'h1);
    bus_write(A_KEY, MAGIC, 4'h7);
    bus_read("key_be", A_STATUS, 32'h200);
    bus_write(A_STATUS, 32'h200, 4'h1);

    // Channel out of range
    bus_write(A_KEY, MAGIC, 4'hF);
    bus_write(A_CTRL, 32'h0000_0502, 4'hF);
    chk("arg_drain", 32'(drain_req_o), 32'd0);
    bus_read("arg_err", A_STATUS, 32'h800);
    bus_write(A_STATUS, 32'h800, 4'h1);

    // Drain timeout with a busy KEY write
    bus_write(A_KEY, MAGIC, 4'hF);
    bus_write(A_CTRL, 32'h0000_0001, 4'hF);
    chk("tmo_drain_hi", 32'(drain_req_o), 32'h1);
    bus_write(A_KEY, MAGIC, 4'hF);
    repeat (60) step();
    chk("tmo_still_hi", 32'(drain_req_o), 32'h1);
    repeat (8) step();
    chk("tmo_drain_lo", 32'(drain_req_o), 32'd0);
    bus_read("tmo_err", A_STATUS, 32'h1400);
    bus_read("tmo_lvl", A_LEVEL, 32'h0000_000C);
    bus_write(A_STATUS, 32'h3F00, 4'hF);
    bus_read("tmo_clr", A_STATUS, 32'd0);

    // Same-level commit with ack already high
    drain_ack_i = 2'b10;
    bus_write(A_KEY, MAGIC, 4'hF);
    bus_write(A_CTRL, 32'h0000_0103, 4'hF);
    chk("same_drain", 32'(drain_req_o), 32'h2);
    step();
    chk("same_change", 32'(change_o), 32'd1);
    chk("same_lvl", 32'(sec_lvl_o), 32'hC);
    drain_ack_i = 2'b00;
    step();

`ifdef SECURE_LEVEL_CTRL_LOCK_EN
    bus_write(A_LOCK, 32'h1, 4'h1);
    bus_read("locked", A_STATUS, 32'h4);
    bus_write(A_KEY, MAGIC, 4'hF);
    bus_write(A_CTRL, 32'h0000_0001, 4'hF);
    chk("lock_drain", 32'(drain_req_o), 32'd0);
    bus_read("lock_err", A_STATUS, 32'h2004);
    bus_read("lock_lvl", A_LEVEL, 32'h0000_000C);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    bus_read("unlock_rst", A_STATUS, 32'd0);
`else
    bus_write(A_LOCK, 32'h1, 4'h1);
    bus_read("nolock", A_STATUS, 32'd0);
`endif

    // Reset during DRAIN aborts and restores levels
    bus_write(A_KEY, MAGIC, 4'hF);
    bus_write(A_CTRL, 32'h0000_0002, 4'hF);
    chk("pre_rst_drain", 32'(drain_req_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_drain", 32'(drain_req_o), 32'd0);
    chk("mid_rst_lvl", 32'(sec_lvl_o), 32'd0);
    step();
    rst_ni = 1'b1;
    step();
    bus_read("post_rst_level", A_LEVEL, 32'd0);
    bus_read("post_rst_status", A_STATUS, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secure_level_ctrl.md
# secure_level_ctrl

Memory-mapped security-level controller for multiple security domains (harts or bus masters). It holds one security level per channel and changes a level only through a keyed, drain-acknowledged transition sequence, with an optional until-reset lock. It sits on the peripheral bus beside the PMP secure extension and drives the per-channel level inputs of the PMP checkers.

## Interface
Parameters:
- NUM_CH, 2: number of channels; 1..8.
- LVL_W, 2: security-level width per channel; 1..4.
- RST_LVL, 0: reset level of every channel.
- KEY, 32'h5EC0_0A5A: magic value that arms a transition.
- ARM_WINDOW, 16: cycles an armed state stays valid; must be at least 1.
- TIMEOUT, 64: maximum cycles spent waiting for drain acknowledge; must be at least 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  bus request.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address; only [4:2] decoded.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data, registered.
- sec_lvl_o  out  NUM_CH*LVL_W  packed levels; channel c at [c*LVL_W +: LVL_W].
- drain_req_o  out  NUM_CH  request to flush the channel's in-flight traffic.
- drain_ack_i  in  NUM_CH  flush complete; level-sensitive.
- change_o  out  1  one-cycle pulse on every committed level change.

## Operation
Register map (word index = addr_i[4:2]):
- 0 LEVEL, read-only: sec_lvl_o zero-extended.
- 1 CTRL, write-only: [15:8] channel, [LVL_W-1:0] target level.
- 2 KEY, write-only.
- 3 STATUS: [0] busy, [1] armed, [2] locked, [8] ERR_NOKEY, [9] ERR_KEY, [10] ERR_BUSY, [11] ERR_ARG, [12] ERR_TMO, [13] ERR_LOCK.
  - Error bits are sticky.
  - Writing 1 to an error bit clears it.
  - Other STATUS bits are read-only.
- 4 LOCK: write [0]=1 sets locked. Locked can only be cleared by reset.
- Indices 5..7: read 0; writes are ignored.

Write acceptance:
- CTRL, STATUS and LOCK writes require be_i[0].
- A KEY write with be_i != 4'hF is a wrong key.

FSM states: IDLE, ARMED, DRAIN, COMMIT.
- IDLE:
  - KEY write equal to KEY goes to ARMED and loads the window counter with ARM_WINDOW.
  - KEY write not equal to KEY sets ERR_KEY.
  - CTRL write sets ERR_NOKEY and is ignored.
- ARMED:
  - The window counter decrements every cycle; at 0 the FSM returns to IDLE.
  - A valid CTRL write latches the channel and target, loads the timeout counter with TIMEOUT, and goes to DRAIN.
  - CTRL write with channel >= NUM_CH sets ERR_ARG and goes to IDLE.
  - Wrong KEY write sets ERR_KEY and goes to IDLE.
  - Correct KEY write reloads the window.
- DRAIN:
  - drain_req_o[ch] = 1.
  - If drain_ack_i[ch] = 1, go to COMMIT.
  - Otherwise decrement the timeout counter; at 0, set ERR_TMO and go to IDLE with the level unchanged.
  - KEY or CTRL writes set ERR_BUSY and are ignored.
- COMMIT:
  - Writes the target into the channel level and pulses change_o.
  - Goes to IDLE the next cycle.
  - drain_req_o is 0 in this state.
- Locked:
  - Every CTRL write sets ERR_LOCK and is ignored.
  - A KEY write while locked never arms.
  - Locking during ARMED forces IDLE.
  - Locking during DRAIN does not abort the transition in flight.
- A commit to the same level as the current one still drains and pulses change_o.

## Timing
- Reset values:
  - rvalid_o = 0, rdata_o = 0, drain_req_o = 0, change_o = 0.
  - Every level = RST_LVL.
  - FSM in IDLE, all STATUS bits 0.
- Any req_i in cycle t gives rvalid_o = 1 in t+1, with rdata_o valid in t+1; for writes rdata_o = 0.
- State effects of a write take effect in t+1. STATUS read in t+1 reflects the write from t.
- drain_req_o rises in t+1 after the CTRL write.
- If drain_ack_i is high in cycle d:
  - COMMIT is in d+1, with sec_lvl_o updated and change_o = 1 in d+1.
  - drain_req_o falls in d+1.
- If an error set and a W1C clear of the same bit occur in one cycle, the set wins.
- Reset mid-DRAIN aborts the transition and all levels return to RST_LVL.

## Configuration
- SECURE_LEVEL_CTRL_LOCK_EN defined: the LOCK register and locked behaviour are as described above.
- Not defined:
  - LOCK writes are ignored.
  - STATUS[2] and ERR_LOCK read 0.
  - No lock state is implemented.

## Test plan
- Reset, read LEVEL with NUM_CH=2, RST_LVL=0 -> rdata_o=0, rvalid_o=1 one cycle after req_i.
- KEY=5EC00A5A, then CTRL ch1 lvl 3, drain_ack_i[1] raised 5 cycles later -> drain_req_o[1] high for 5 cycles, change_o pulse, LEVEL reads 0x0000000C.
- CTRL write without prior KEY -> STATUS reads 0x100; write 0x100 to STATUS -> reads 0.
- KEY, then wait ARM_WINDOW+1 cycles, then CTRL -> ERR_NOKEY set, levels unchanged.
- KEY, CTRL ch0 lvl 1, drain_ack_i held 0 -> after TIMEOUT cycles ERR_TMO set, drain_req_o=0, LEVEL unchanged; KEY written during DRAIN sets ERR_BUSY.
- With SECURE_LEVEL_CTRL_LOCK_EN: LOCK=1, then KEY and CTRL -> ERR_LOCK set, STATUS[2]=1, levels unchanged until reset.
